// File: rtl/vn_sweep_scheduler.sv
// Sequences a shared VariableNode datapath over NUM_VN nodes per iteration and
// alternates VN sweeps with check-node phases until convergence or MAX_ITER.
module vn_sweep_scheduler #(
  parameter int unsigned NUM_VN     = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned MAX_ITER   = 8,
  parameter int unsigned ITER_W     = 4,
  parameter int unsigned VN_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_cn_done,
  input  logic [1:0]            i_symbol_in,
  output logic                  o_busy,
  output logic                  o_vn_en,
  output logic [ADDR_W-1:0]     o_vn_addr,
  output logic                  o_wb_en,
  output logic [ADDR_W-1:0]     o_wb_addr,
  output logic                  o_cn_start,
  output logic [ITER_W-1:0]     o_iter_cnt,
  output logic                  o_done,
  output logic                  o_converged,
  output logic [2*NUM_VN-1:0]   o_decisions
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_VN - 1);
  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE, S_VN_ISSUE, S_VN_DRAIN, S_CN_WAIT, S_FINISH
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_busy, r_vn_en, r_cn_start, r_done, r_conv, r_chg;
  logic [ADDR_W-1:0]   r_vn_addr;
  logic [ITER_W-1:0]   r_iter;
  logic [VN_LATENCY-1:0] r_dl_en;
  logic [ADDR_W-1:0]   r_dl_addr [VN_LATENCY];
  logic [1:0]          r_dec [NUM_VN];

  logic                w_vn_en_nxt, w_cn_start_nxt, w_done_nxt, w_conv_nxt, w_chg_nxt;
  logic [ADDR_W-1:0]   w_vn_addr_nxt;
  logic [ITER_W-1:0]   w_iter_nxt, w_iter_inc;
  logic                w_wb_en, w_wr_chg, w_dl_empty;
  logic [ADDR_W-1:0]   w_wb_addr;

  assign w_wb_en    = r_dl_en[VN_LATENCY-1];
  assign w_wb_addr  = r_dl_addr[VN_LATENCY-1];
  assign w_wr_chg   = w_wb_en && (r_dec[w_wb_addr] != i_symbol_in);
  assign w_dl_empty = ~r_vn_en & ~(|r_dl_en);
  assign w_iter_inc = r_iter + ITER_W'(1);

  assign o_busy      = r_busy;
  assign o_vn_en     = r_vn_en;
  assign o_vn_addr   = r_vn_addr;
  assign o_wb_en     = w_wb_en;
  assign o_wb_addr   = w_wb_addr;
  assign o_cn_start  = r_cn_start;
  assign o_iter_cnt  = r_iter;
  assign o_done      = r_done;
  assign o_converged = r_conv;

  always_comb begin
    o_decisions = '0;
    for (int n = 0; n < NUM_VN; n++) o_decisions[2*n +: 2] = r_dec[n];
  end

  // Next-state and next-output logic; the decide step runs once the delay line drains.
  always_comb begin
    w_state_nxt    = r_state;
    w_vn_en_nxt    = 1'b0;
    w_vn_addr_nxt  = '0;
    w_cn_start_nxt = 1'b0;
    w_done_nxt     = 1'b0;
    w_iter_nxt     = r_iter;
    w_conv_nxt     = r_conv;
    w_chg_nxt      = r_chg | w_wr_chg;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_VN_ISSUE;
          w_vn_en_nxt = 1'b1;
          w_iter_nxt  = '0;
          w_conv_nxt  = 1'b0;
          w_chg_nxt   = 1'b0;
        end
      end
      S_VN_ISSUE: begin
        if (r_vn_addr == LAST_ADDR) begin
          w_state_nxt = S_VN_DRAIN;
        end else begin
          w_vn_en_nxt   = 1'b1;
          w_vn_addr_nxt = r_vn_addr + ADDR_W'(1);
        end
      end
      S_VN_DRAIN: begin
        if (w_dl_empty) begin
          w_iter_nxt = w_iter_inc;
          if (!r_chg && (r_iter != '0)) begin
            w_conv_nxt  = 1'b1;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_FINISH;
          end else if (w_iter_inc == ITER_LIMIT) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_FINISH;
          end else begin
            w_cn_start_nxt = 1'b1;
            w_chg_nxt      = 1'b0;
            w_state_nxt    = S_CN_WAIT;
          end
        end
      end
      // CN_DONE coinciding with the CN_START pulse belongs to no phase yet.
      S_CN_WAIT: begin
        if (!r_cn_start && i_cn_done) begin
          w_state_nxt = S_VN_ISSUE;
          w_vn_en_nxt = 1'b1;
        end
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_vn_en    <= 1'b0;
      r_vn_addr  <= '0;
      r_cn_start <= 1'b0;
      r_done     <= 1'b0;
      r_conv     <= 1'b0;
      r_chg      <= 1'b0;
      r_iter     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_vn_en    <= w_vn_en_nxt;
      r_vn_addr  <= w_vn_addr_nxt;
      r_cn_start <= w_cn_start_nxt;
      r_done     <= w_done_nxt;
      r_conv     <= w_conv_nxt;
      r_chg      <= w_chg_nxt;
      r_iter     <= w_iter_nxt;
    end
  end

  // {en, addr} delay line aligning write-back with SYMBOL_IN.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dl_en <= '0;
      for (int i = 0; i < VN_LATENCY; i++) r_dl_addr[i] <= '0;
    end else begin
      r_dl_en[0]   <= r_vn_en;
      r_dl_addr[0] <= r_vn_addr;
      for (int i = 1; i < VN_LATENCY; i++) begin
        r_dl_en[i]   <= r_dl_en[i-1];
        r_dl_addr[i] <= r_dl_addr[i-1];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int n = 0; n < NUM_VN; n++) r_dec[n] <= '0;
    end else if (w_wb_en) begin
      r_dec[w_wb_addr] <= i_symbol_in;
    end
  end

endmodule
